mul_div_seq: RTL and testbench
==============================

MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width; only 4 is supported and verified, matching add_sub.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  1  0 = unsigned multiply a*b, 1 = unsigned divide a/b.
REQ-006 SHALL have port a  input  4  multiplicand / dividend.
REQ-007 SHALL have port b  input  4  multiplier / divisor.
REQ-008 SHALL have port busy  output  1  high in RUN and DONE states.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port result  output  8  multiply: 8-bit product; divide: [7:4] remainder, [3:0] quotient.
REQ-011 SHALL have port div_by_zero  output  1  set with done when op=1 and captured b=0; held with result.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start=1, RUN->DONE after 4 iterations, DONE->IDLE unconditionally.
REQ-013 SHALL capture a, b, op on the accepting edge; input changes while busy have no effect.
REQ-014 SHALL perform exactly one iteration per RUN cycle, with a 2-bit iteration counter from 0 to 3.
REQ-015 SHALL give fixed latency: start accepted at edge k; iterations at edges k+1..k+4; done=1 in the cycle after edge k+4; IDLE after edge k+5.
REQ-016 SHALL perform all data add/subtract through the single add_sub instance; M=0 for multiply, M=1 for divide.
REQ-017 Multiply SHALL be shift-add over a 9-bit {carry, acc[3:0], q[3:0]} with acc=0 and q=b at start.
REQ-018 Each multiply iteration SHALL set {carry, acc} = add_sub(acc, a, M=0) if q[0]=1, else {0, acc}, then shift the 9-bit value right by one.
REQ-019 Divide SHALL be restoring over {r[3:0], q[3:0]} with r=0 and q=a at start.
REQ-020 Each divide iteration SHALL shift {r,q} left by one, keeping the shifted-out bit t, then compute d = add_sub(r_shifted, b, M=1).
REQ-021 The divide subtraction SHALL be accepted when t=1 or C=1: r=d and q[0]=1; otherwise r is restored and q[0]=0.
REQ-022 Divide by zero SHALL take the same latency and SHALL yield quotient 4'hF, remainder = a, div_by_zero=1.
REQ-023 result and div_by_zero SHALL update only at edge k+4 and hold until the next accepted start.
REQ-024 start in RUN or DONE SHALL be ignored and not queued; no back-to-back accept from DONE.
REQ-025 rst asserted in any state SHALL abort the operation at the next edge; rst wins over a simultaneous start.

Reset
REQ-026 On rst the block SHALL go to state IDLE and clear counter, datapath registers, result, done, busy and div_by_zero to 0.
REQ-027 The first start SHALL be accepted on the first edge with rst=0 and start=1.

Structure
REQ-028 A shared package SHALL hold the state enum, the OP_MUL=0 / OP_DIV=1 constants, WIDTH=4 and ITERS=4.
REQ-029 The single sub-module SHALL be the existing add_sub (ports A, B, M, S, C), instantiated once, with no other adders on the data path.
REQ-030 The controller FSM and datapath registers SHALL live in mul_div_seq.

Verification
REQ-031 op=0, a=3, b=5, start -> done 5 cycles later, result=8'h0F, div_by_zero=0.
REQ-032 op=0, a=15, b=15 -> result=8'hE1; op=0, a=0, b=9 -> result=8'h00.
REQ-033 op=1, a=13, b=4 -> result=8'h13 (R=1, Q=3); op=1, a=15, b=1 -> result=8'h0F.
REQ-034 op=1, a=7, b=0 -> result=8'h7F, div_by_zero=1; next op=0 accept clears div_by_zero at its done.
REQ-035 start pulsed with new operands during RUN and DONE -> ignored, first result unchanged, busy drops after DONE.
REQ-036 rst asserted at iteration 2 -> next cycle busy=0, done=0, result=0; the next start completes correctly.

Source files
------------

// File: rtl/mul_div_seq_pkg.sv
// ============================================================================
// Module   : mul_div_seq_pkg
// Purpose  : Shared types and constants for the sequential multiply/divide unit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_div_seq_pkg;

   localparam int WIDTH = 4;
   localparam int ITERS = 4;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/add_sub.sv
// ============================================================================
// Module   : add_sub
// Purpose  : Ripple add/subtract; M=0 gives A+B, M=1 gives A-B (C=1 means no borrow)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_sub #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             M,
   output logic [WIDTH-1:0] S,
   output logic             C
);

   logic [WIDTH-1:0] w_b;

   // Two's-complement subtract: invert B and inject M as the carry-in.
   assign w_b    = B ^ {WIDTH{M}};
   assign {C, S} = {1'b0, A} + {1'b0, w_b} + {{WIDTH{1'b0}}, M};

endmodule

`default_nettype wire

// File: rtl/mul_div_seq.sv
// ============================================================================
// Module   : mul_div_seq
// Purpose  : Fixed-latency shift-add multiplier / restoring divider over one add_sub
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_seq
   import mul_div_seq_pkg::*;
#(
   parameter int WIDTH = mul_div_seq_pkg::WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               div_by_zero
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [1:0]         r_cnt;
   logic               r_op;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_q;
   logic [2*WIDTH-1:0] r_result;
   logic               r_dbz;

   logic               w_last;
   logic [WIDTH-1:0]   w_shl_r;
   logic               w_t;
   logic [WIDTH-1:0]   w_as_a;
   logic [WIDTH-1:0]   w_as_b;
   logic [WIDTH-1:0]   w_as_s;
   logic               w_as_c;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH-1:0]   w_acc_nxt;
   logic [WIDTH-1:0]   w_q_nxt;

   assign w_last  = (r_cnt == 2'(ITERS - 1));
   assign w_shl_r = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
   assign w_t     = r_acc[WIDTH-1];

   // The single adder is shared: multiply adds a to acc, divide subtracts b from shifted r.
   assign w_as_a = (r_op == OP_DIV) ? w_shl_r : r_acc;
   assign w_as_b = (r_op == OP_DIV) ? r_b : r_a;

   add_sub #(
      .WIDTH (WIDTH)
   ) u_add_sub (
      .A (w_as_a),
      .B (w_as_b),
      .M (r_op),
      .S (w_as_s),
      .C (w_as_c)
   );

   always_comb begin
      w_mul_sum = {1'b0, r_acc};
      w_acc_nxt = r_acc;
      w_q_nxt   = r_q;
      if (r_op == OP_MUL) begin
         if (r_q[0]) begin
            w_mul_sum = {w_as_c, w_as_s};
         end
         w_acc_nxt = w_mul_sum[WIDTH:1];
         w_q_nxt   = {w_mul_sum[0], r_q[WIDTH-1:1]};
      end else begin
         // A shifted-out 1 means r already exceeds b, so the subtract is always valid.
         if (w_t || w_as_c) begin
            w_acc_nxt = w_as_s;
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
         end else begin
            w_acc_nxt = w_shl_r;
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= 2'd0;
         r_op     <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_q      <= '0;
         r_result <= '0;
         r_dbz    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_op  <= op;
                  r_a   <= a;
                  r_b   <= b;
                  r_acc <= '0;
                  r_q   <= (op == OP_DIV) ? a : b;
                  r_cnt <= 2'd0;
               end
            end
            RUN: begin
               r_acc <= w_acc_nxt;
               r_q   <= w_q_nxt;
               r_cnt <= r_cnt + 2'd1;
               if (w_last) begin
                  r_result <= {w_acc_nxt, w_q_nxt};
                  r_dbz    <= (r_op == OP_DIV) && (r_b == '0);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign result      = r_result;
   assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_seq.sv
// ============================================================================
// Module   : tb_mul_div_seq
// Purpose  : Directed vector bench for mul_div_seq
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_seq;

   typedef struct {
      logic       op;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] res;
      logic       dbz;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic       op;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       div_by_zero;

   int n_vec;
   int n_fail;

   vec_t vecs [12];

   mul_div_seq #(
      .WIDTH (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation from IDLE and check latency, result and flag.
   task automatic run_op(input string tag, input logic o, input logic [3:0] aa,
                         input logic [3:0] bb, input logic [7:0] er, input logic ed);
      int lat;
      op    = o;
      a     = aa;
      b     = bb;
      start = 1'b1;
      tick();
      start = 1'b0;
      op    = ~o;
      a     = ~aa;
      b     = ~bb;
      check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
      lat = 0;
      while (!done && lat < 10) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'd4);
      check({tag, " result"}, 32'(result), 32'(er));
      check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ed));
      tick();
      check({tag, " busy_after_done"}, 32'({busy, done}), 32'd0);
   endtask

   initial begin
      n_vec  = 0;
      n_fail = 0;

      vecs[0]  = '{op: 1'b0, a: 4'd3,  b: 4'd5,  res: 8'h0F, dbz: 1'b0};
      vecs[1]  = '{op: 1'b0, a: 4'd15, b: 4'd15, res: 8'hE1, dbz: 1'b0};
      vecs[2]  = '{op: 1'b0, a: 4'd0,  b: 4'd9,  res: 8'h00, dbz: 1'b0};
      vecs[3]  = '{op: 1'b1, a: 4'd13, b: 4'd4,  res: 8'h13, dbz: 1'b0};
      vecs[4]  = '{op: 1'b1, a: 4'd15, b: 4'd1,  res: 8'h0F, dbz: 1'b0};
      vecs[5]  = '{op: 1'b1, a: 4'd7,  b: 4'd0,  res: 8'h7F, dbz: 1'b1};
      vecs[6]  = '{op: 1'b0, a: 4'd2,  b: 4'd3,  res: 8'h06, dbz: 1'b0};
      vecs[7]  = '{op: 1'b0, a: 4'd12, b: 4'd11, res: 8'h84, dbz: 1'b0};
      vecs[8]  = '{op: 1'b1, a: 4'd9,  b: 4'd3,  res: 8'h03, dbz: 1'b0};
      vecs[9]  = '{op: 1'b1, a: 4'd3,  b: 4'd7,  res: 8'h30, dbz: 1'b0};
      vecs[10] = '{op: 1'b1, a: 4'd14, b: 4'd5,  res: 8'h42, dbz: 1'b0};
      vecs[11] = '{op: 1'b1, a: 4'd0,  b: 4'd0,  res: 8'h0F, dbz: 1'b1};

      rst   = 1'b1;
      start = 1'b1;
      op    = 1'b0;
      a     = 4'd1;
      b     = 4'd1;
      tick();
      tick();
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset result", 32'(result), 32'd0);
      check("reset div_by_zero", 32'(div_by_zero), 32'd0);
      rst   = 1'b0;
      start = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].dbz);
      end

      // Start pulses with new operands during RUN and DONE must not be taken.
      op    = 1'b0;
      a     = 4'd3;
      b     = 4'd5;
      start = 1'b1;
      tick();
      op = 1'b1;
      a  = 4'd15;
      b  = 4'd15;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("ignore run%0d busy_done", i), 32'({busy, done}), 32'd2);
      end
      tick();
      check("ignore done pulse", 32'({busy, done}), 32'd3);
      check("ignore result", 32'(result), 32'h0F);
      tick();
      start = 1'b0;
      check("ignore no_requeue busy", 32'(busy), 32'd0);
      tick();
      check("ignore idle busy", 32'(busy), 32'd0);
      check("ignore result held", 32'(result), 32'h0F);
      check("ignore div_by_zero held", 32'(div_by_zero), 32'd0);

      // Reset in the middle of a divide aborts it and clears the result.
      op    = 1'b1;
      a     = 4'd13;
      b     = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort result", 32'(result), 32'd0);
      check("abort div_by_zero", 32'(div_by_zero), 32'd0);
      rst = 1'b0;
      run_op("after_abort", 1'b1, 4'd13, 4'd4, 8'h13, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
